// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam int          TIMEOUT_DEF = 15;
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin grant decision; purely combinational.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_gnt,
    output logic       any,
    output logic       winner
);

    assign any = |valid;

    // On contention the master that was not served last goes next.
    assign winner = (&valid) ? ~last_gnt : valid[1];

endmodule

// File: rtl/sram_arbiter.sv
// Serialises two valid/ready masters onto one SRAM port, with a per-access
// timeout that completes the access with an error and a marker data word.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 13,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 m0_valid,
    input  logic [ADDRWIDTH-1:0] m0_addr,
    input  logic [3:0]           m0_wstrb,
    input  logic [31:0]          m0_wdata,
    output logic                 m0_ready,
    output logic [31:0]          m0_rdata,
    output logic                 m0_err,

    input  logic                 m1_valid,
    input  logic [ADDRWIDTH-1:0] m1_addr,
    input  logic [3:0]           m1_wstrb,
    input  logic [31:0]          m1_wdata,
    output logic                 m1_ready,
    output logic [31:0]          m1_rdata,
    output logic                 m1_err,

    output logic                 sram_sel,
    output logic [3:0]           sram_wstrb,
    output logic [ADDRWIDTH-1:0] sram_addr,
    output logic [31:0]          sram_data_i,
    input  logic                 sram_ready,
    input  logic [31:0]          sram_data_o
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state;
    logic          gnt;
    logic          last_gnt;
    logic [TW-1:0] timer;

    logic          arb_any;
    logic          arb_winner;
    logic          timed_out;
    logic [31:0]   done_data;

    rr_arb2 u_arb (
        .valid    ({m1_valid, m0_valid}),
        .last_gnt (last_gnt),
        .any      (arb_any),
        .winner   (arb_winner)
    );

    // A real sram_ready always wins over a coincident timeout.
    assign timed_out = !sram_ready && (timer == TW'(TIMEOUT));
    assign done_data = sram_ready ? sram_data_o : ERR_DATA;

    // NOTE: all state and outputs are registered and updated with <= so every
    // branch of the case reads the pre-edge values, never a half-updated mix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last_gnt    <= 1'b1;
            timer       <= '0;
            sram_sel    <= 1'b0;
            sram_wstrb  <= '0;
            sram_addr   <= '0;
            sram_data_i <= '0;
            m0_ready    <= 1'b0;
            m0_rdata    <= '0;
            m0_err      <= 1'b0;
            m1_ready    <= 1'b0;
            m1_rdata    <= '0;
            m1_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt         <= arb_winner;
                        sram_sel    <= 1'b1;
                        sram_addr   <= arb_winner ? m1_addr  : m0_addr;
                        sram_wstrb  <= arb_winner ? m1_wstrb : m0_wstrb;
                        sram_data_i <= arb_winner ? m1_wdata : m0_wdata;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (sram_ready || timed_out) begin
                        sram_sel   <= 1'b0;
                        sram_wstrb <= '0;
                        timer      <= '0;
                        state      <= DONE;
                        if (gnt) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= done_data;
                            m1_err   <= timed_out;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= done_data;
                            m0_err   <= timed_out;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    // sel stays low here so the sram's stale ready drains before the next grant.
                    m0_ready <= 1'b0;
                    m0_err   <= 1'b0;
                    m1_ready <= 1'b0;
                    m1_err   <= 1'b0;
                    last_gnt <= gnt;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a registered byte-laned sram, directed scenarios and
// randomized two-master traffic checked every cycle by a transaction-level model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int ADW   = 13;
    localparam int TMO   = 15;
    localparam int WORDS = 1 << (ADW - 2);

    logic            clk = 1'b0;
    logic            reset;
    logic            m0_valid, m0_ready, m0_err;
    logic [ADW-1:0]  m0_addr;
    logic [3:0]      m0_wstrb;
    logic [31:0]     m0_wdata, m0_rdata;
    logic            m1_valid, m1_ready, m1_err;
    logic [ADW-1:0]  m1_addr;
    logic [3:0]      m1_wstrb;
    logic [31:0]     m1_wdata, m1_rdata;
    logic            sram_sel;
    logic            sram_ready = 1'b0;
    logic [3:0]      sram_wstrb;
    logic [ADW-1:0]  sram_addr;
    logic [31:0]     sram_data_i;
    logic [31:0]     sram_data_o = '0;

    logic            stuck = 1'b0;
    logic            mem_loaded = 1'b0;
    logic [31:0]     sram_mem  [WORDS];
    logic [31:0]     model_mem [WORDS];

    int total = 0;
    int bad   = 0;

    // Model state: grant bookkeeping in cycles, not FSM states.
    int             mc = 0;
    int             gnt, g_cyc, last_w, idle_from, low_run;
    logic [1:0]     pv;
    logic [ADW-1:0] pa [2];
    logic [3:0]     pw [2];
    logic [31:0]    pd [2];
    logic [ADW-1:0] ra;
    logic [3:0]     rw;
    logic [31:0]    rd;
    logic [31:0]    exp_rd [2];
    int             order [$];

    always #5 clk = ~clk;

    sram_arbiter #(.ADDRWIDTH(ADW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_valid    (m0_valid),
        .m0_addr     (m0_addr),
        .m0_wstrb    (m0_wstrb),
        .m0_wdata    (m0_wdata),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m0_err      (m0_err),
        .m1_valid    (m1_valid),
        .m1_addr     (m1_addr),
        .m1_wstrb    (m1_wstrb),
        .m1_wdata    (m1_wdata),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .m1_err      (m1_err),
        .sram_sel    (sram_sel),
        .sram_wstrb  (sram_wstrb),
        .sram_addr   (sram_addr),
        .sram_data_i (sram_data_i),
        .sram_ready  (sram_ready),
        .sram_data_o (sram_data_o)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'h1234_5678;
            8:       return 32'h5566_7788;
            default: return {16'(i), 16'hA5A5};
        endcase
    endfunction

    // Registered sram: ready follows sel one cycle later, read data is the pre-write word.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < WORDS; i++) sram_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
            sram_ready <= 1'b0;
        end else begin
            sram_ready <= sram_sel && !stuck;
            if (sram_sel && !stuck) begin
                sram_data_o <= sram_mem[sram_addr[ADW-1:2]];
                for (int b = 0; b < 4; b++)
                    if (sram_wstrb[b])
                        sram_mem[sram_addr[ADW-1:2]][8*b +: 8] <= sram_data_i[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, mc);
        end
    endtask

    function automatic logic get_ready(input int m);
        return (m == 0) ? m0_ready : m1_ready;
    endfunction

    function automatic logic get_valid(input int m);
        return (m == 0) ? m0_valid : m1_valid;
    endfunction

    task automatic drive(input int m, input logic v, input logic [ADW-1:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (m == 0) begin
            m0_valid = v; m0_addr = a; m0_wstrb = s; m0_wdata = d;
        end else begin
            m1_valid = v; m1_addr = a; m1_wstrb = s; m1_wdata = d;
        end
    endtask

    // Per-cycle check: sel is high for exactly the access window of the
    // round-robin winner, ready pulses once at its end, rdata holds otherwise.
    task automatic model_step();
        int          done_c;
        logic        exp_r;
        logic [31:0] exp_d;
        logic [ADW-3:0] idx;
        mc++;
        if (reset) begin
            check("reset_sel", 32'(sram_sel), 32'd0);
            check("reset_ready", 32'({m1_ready, m0_ready}), 32'd0);
            check("reset_err", 32'({m1_err, m0_err}), 32'd0);
            check("reset_rdata", m0_rdata | m1_rdata, 32'd0);
            gnt = -1; last_w = 1; low_run = 2; idle_from = mc + 1;
            exp_rd[0] = '0; exp_rd[1] = '0;
        end else begin
            if (gnt == -1) begin
                if (mc - 1 >= idle_from)
                    check("grant_when_requested", 32'(sram_sel), 32'(pv != 2'b00));
                if (sram_sel) begin
                    gnt = (pv == 2'b11) ? 1 - last_w : (pv[1] ? 1 : 0);
                    check("sel_gap_ge2", 32'(low_run >= 2), 32'd1);
                    g_cyc = mc;
                    ra = pa[gnt]; rw = pw[gnt]; rd = pd[gnt];
                end
            end
            done_c = g_cyc + (stuck ? TMO + 1 : 2);
            check("sram_sel", 32'(sram_sel), 32'(gnt != -1 && mc < done_c));
            if (gnt != -1 && sram_sel) begin
                check("sram_addr", 32'(sram_addr), 32'(ra));
                check("sram_wstrb", 32'(sram_wstrb), 32'(rw));
                check("sram_data_i", sram_data_i, rd);
            end
            for (int m = 0; m < 2; m++) begin
                exp_r = (gnt == m) && (mc == done_c);
                check(m ? "m1_ready" : "m0_ready", 32'(get_ready(m)), 32'(exp_r));
                if (exp_r) begin
                    if (stuck) begin
                        exp_d = ERR_DATA;
                    end else begin
                        idx   = ra[ADW-1:2];
                        exp_d = model_mem[idx];
                        for (int b = 0; b < 4; b++)
                            if (rw[b]) model_mem[idx][8*b +: 8] = rd[8*b +: 8];
                    end
                    exp_rd[m] = exp_d;
                    order.push_back(m);
                end
                check(m ? "m1_rdata" : "m0_rdata", m ? m1_rdata : m0_rdata, exp_rd[m]);
                check(m ? "m1_err" : "m0_err", 32'(m ? m1_err : m0_err), 32'(exp_r && stuck));
            end
            if (gnt != -1 && mc == done_c) begin
                last_w = gnt; gnt = -1; idle_from = mc + 1;
            end
            low_run = sram_sel ? 0 : low_run + 1;
        end
        pv = {m1_valid, m0_valid};
        pa[0] = m0_addr;  pa[1] = m1_addr;
        pw[0] = m0_wstrb; pw[1] = m1_wstrb;
        pd[0] = m0_wdata; pd[1] = m1_wdata;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic single(input int m, input logic [ADW-1:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rdat,
                          output logic e, output int lat);
        drive(m, 1'b1, a, s, d);
        lat = 0; rdat = '0; e = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (get_ready(m)) begin
                lat  = n;
                rdat = (m == 0) ? m0_rdata : m1_rdata;
                e    = (m == 0) ? m0_err : m1_err;
                break;
            end
        end
        drive(m, 1'b0, '0, '0, '0);
        tick();
    endtask

    task automatic run_traffic(input int ncyc, input int gap_max, input logic [1:0] en);
        int gap [2];
        int wait_n [2];
        gap[0] = 0; gap[1] = 0; wait_n[0] = 0; wait_n[1] = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (get_valid(m)) begin
                    if (get_ready(m)) begin
                        drive(m, 1'b0, '0, '0, '0);
                        gap[m]    = $urandom_range(gap_max, 0);
                        wait_n[m] = 0;
                    end else if (++wait_n[m] > 40) begin
                        check("request_wait_bound", 32'(wait_n[m]), 32'd40);
                        drive(m, 1'b0, '0, '0, '0);
                        wait_n[m] = 0;
                    end
                end else if (en[m]) begin
                    if (gap[m] > 0) gap[m]--;
                    else drive(m, 1'b1, ADW'($urandom_range(63, 0)),
                               ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0,
                               $urandom);
                end
            end
            tick();
        end
    endtask

    logic [31:0] rdat;
    logic        e;
    int          lat;

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        gnt = -1; last_w = 1; g_cyc = 0; idle_from = 0; low_run = 2;
        pv = '0; ra = '0; rw = '0; rd = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < WORDS; i++) model_mem[i] = init_word(i);
        repeat (3) tick();
        check("init_sel", 32'(sram_sel), 32'd0);
        check("init_ready", 32'({m1_ready, m0_ready}), 32'd0);
        reset = 1'b0;
        tick();

        // Uncontended read: ready three cycles after valid.
        single(0, 13'h0010, 4'h0, 32'h0, rdat, e, lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_rdata", rdat, 32'h1234_5678);
        check("t1_err", 32'(e), 32'd0);

        // Partial write by m1, read back by m0.
        single(1, 13'h0020, 4'b0011, 32'hAABB_CCDD, rdat, e, lat);
        check("t2_write_latency", 32'(lat), 32'd3);
        single(0, 13'h0020, 4'h0, 32'h0, rdat, e, lat);
        check("t2_readback", rdat, 32'h5566_CCDD);

        // Silent sram: error completion after TMO+1 access cycles.
        stuck = 1'b1;
        single(0, 13'h0040, 4'h0, 32'h0, rdat, e, lat);
        check("t5_latency", 32'(lat), 32'(TMO + 2));
        check("t5_err", 32'(e), 32'd1);
        check("t5_rdata", rdat, 32'hDEAD_BEEF);
        stuck = 1'b0;
        single(1, 13'h0010, 4'h0, 32'h0, rdat, e, lat);
        check("t5_recover_latency", 32'(lat), 32'd3);
        check("t5_recover_rdata", rdat, 32'h1234_5678);
        check("t5_recover_err", 32'(e), 32'd0);

        // Reset in the middle of an access.
        drive(0, 1'b1, 13'h0010, 4'h0, 32'h0);
        tick();
        tick();
        check("t6_in_access", 32'(sram_sel), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_sel_drop", 32'(sram_sel), 32'd0);
        check("t6_ready_drop", 32'({m1_ready, m0_ready}), 32'd0);
        check("t6_err_drop", 32'({m1_err, m0_err}), 32'd0);
        drive(0, 1'b0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;

        // Both masters request together and keep requesting.
        order.delete();
        run_traffic(20, 0, 2'b11);
        run_traffic(30, 0, 2'b00);
        check("t3_count_ge4", 32'(order.size() >= 4), 32'd1);
        if (order.size() >= 4)
            for (int i = 0; i < 4; i++) check("t3_order", 32'(order[i]), 32'(i % 2));

        // Randomized traffic with idle gaps.
        order.delete();
        run_traffic(800, 3, 2'b11);
        run_traffic(40, 0, 2'b00);
        check("rand_progress", 32'(order.size() > 50), 32'd1);
        check("drain_idle", 32'({m1_valid, m0_valid}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
